// File: rtl/addsub_pkg.sv
// Shared constants and the signed-overflow helper for the pipelined adder/subtractor.
package addsub_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Overflow when both operands share a sign and the result's sign differs
  function automatic logic calc_ovf(input logic a_sign, input logic b_sign, input logic s_sign);
    return (a_sign == b_sign) && (s_sign != a_sign);
  endfunction

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit full adder slice: {co, s} = x + y + ci.
module adder_chunk
  import addsub_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  assign {co, s} = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};

endmodule

// File: rtl/pipelined_addsub.sv
// Carry-pipelined WIDTH-bit adder/subtractor: one CHUNK-bit slice per stage,
// valid/ready stream where every stage advances together under a single enable.
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c0,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c4,
  output logic             ovf
);

  localparam int STAGES = WIDTH / CHUNK;
  localparam int LAST   = STAGES - 1;

  generate
    if (((WIDTH % CHUNK) != 0) || (WIDTH < CHUNK)) begin : g_bad_cfg
      $error("pipelined_addsub: WIDTH must be a non-zero multiple of CHUNK");
    end
  endgenerate

  logic             r_vld [STAGES];
  logic [WIDTH-1:0] r_sum [STAGES];
  logic             r_cy  [STAGES];
  logic [WIDTH-1:0] r_a   [STAGES];
  logic [WIDTH-1:0] r_b   [STAGES];
  logic             r_ovf;

  logic             w_en;
  logic             w_acc;
  logic             w_vin     [STAGES];
  logic [WIDTH-1:0] w_opa     [STAGES];
  logic [WIDTH-1:0] w_opb     [STAGES];
  logic             w_ci      [STAGES];
  logic [WIDTH-1:0] w_psum    [STAGES];
  logic [CHUNK-1:0] w_s       [STAGES];
  logic             w_co      [STAGES];
  logic [WIDTH-1:0] w_sum_nxt [STAGES];

  assign w_en     = out_ready | ~r_vld[LAST];
  assign w_acc    = in_valid & w_en;
  assign in_ready = w_en;

  genvar k;
  generate
    for (k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_first
        // Subtraction folds into addition: a + ~b + ~c0, so c4 reads as "no borrow"
        assign w_vin[k]  = w_acc;
        assign w_opa[k]  = a;
        assign w_opb[k]  = (sub == MODE_SUB) ? ~b : b;
        assign w_ci[k]   = (sub == MODE_SUB) ? ~c0 : c0;
        assign w_psum[k] = {WIDTH{1'b0}};
      end else begin : g_next
        assign w_vin[k]  = r_vld[k-1];
        assign w_opa[k]  = r_a[k-1];
        assign w_opb[k]  = r_b[k-1];
        assign w_ci[k]   = r_cy[k-1];
        assign w_psum[k] = r_sum[k-1];
      end

      adder_chunk #(.CHUNK(CHUNK)) u_add (
        .x  (w_opa[k][k*CHUNK +: CHUNK]),
        .y  (w_opb[k][k*CHUNK +: CHUNK]),
        .ci (w_ci[k]),
        .s  (w_s[k]),
        .co (w_co[k])
      );

      // Upper bits of the partial sum are still zero, so the new slice is ORed in place
      assign w_sum_nxt[k] = w_psum[k] | (WIDTH'(w_s[k]) << (k * CHUNK));
    end
  endgenerate

  // Whole pipeline shifts one stage when the output slot is free or being drained
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        r_vld[i] <= 1'b0;
        r_sum[i] <= {WIDTH{1'b0}};
        r_cy[i]  <= 1'b0;
        r_a[i]   <= {WIDTH{1'b0}};
        r_b[i]   <= {WIDTH{1'b0}};
      end
      r_ovf <= 1'b0;
    end else if (w_en) begin
      for (int i = 0; i < STAGES; i++) begin
        r_vld[i] <= w_vin[i];
        r_sum[i] <= w_sum_nxt[i];
        r_cy[i]  <= w_co[i];
        r_a[i]   <= w_opa[i];
        r_b[i]   <= w_opb[i];
      end
      r_ovf <= calc_ovf(w_opa[LAST][WIDTH-1], w_opb[LAST][WIDTH-1], w_sum_nxt[LAST][WIDTH-1]);
    end
  end

  assign out_valid = r_vld[LAST];
  assign sum       = r_sum[LAST];
  assign c4        = r_cy[LAST];
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub at WIDTH=16, CHUNK=4 (four stages).
module tb_pipelined_addsub;

  localparam int W  = 16;
  localparam int CH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          c0;
  logic          sub;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  sum;
  logic          c4;
  logic          ovf;

  logic [17:0]   sb[$];
  int            errors = 0;
  int            checks = 0;

  pipelined_addsub #(.WIDTH(W), .CHUNK(CH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c0        (c0),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c4        (c4),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Reference: integer arithmetic, result packed as {sum, c4, ovf}
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic ci, input logic s);
    logic [16:0] u;
    logic [15:0] res;
    logic        c;
    int          sx;
    int          sy;
    int          r;
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (!s) begin
      u   = {1'b0, x} + {1'b0, y} + {16'h0000, ci};
      res = u[15:0];
      c   = u[16];
      r   = sx + sy + int'(ci);
    end else begin
      res = x - y - {15'h0000, ci};
      c   = ({1'b0, x} >= ({1'b0, y} + {16'h0000, ci}));
      r   = sx - sy - int'(ci);
    end
    return {res, c, ((r > 32767) || (r < -32768))};
  endfunction

  // One clock: drive at the falling edge, sample just after, update the scoreboard
  task automatic cyc(input logic iv, input logic [15:0] ta, input logic [15:0] tbv,
                     input logic tc0, input logic tsub, input logic tor,
                     output logic emit, output logic ovld, output logic ordy,
                     output logic [17:0] got, output logic [17:0] exp, output logic have_exp);
    @(negedge clk);
    in_valid  = iv;
    a         = ta;
    b         = tbv;
    c0        = tc0;
    sub       = tsub;
    out_ready = tor;
    #1;
    ovld     = out_valid;
    ordy     = in_ready;
    got      = {sum, c4, ovf};
    emit     = out_valid & out_ready;
    have_exp = 1'b0;
    exp      = 18'h0;
    if (emit && (sb.size() > 0)) begin
      exp      = sb.pop_front();
      have_exp = 1'b1;
    end
    if (in_valid & in_ready) sb.push_back(model(ta, tbv, tc0, tsub));
  endtask

  task automatic test_drain(input string tag);
    logic e, v, r, h;
    logic [17:0] g, x;
    for (int i = 0; (i < 40) && (sb.size() > 0); i++) begin
      cyc(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, e, v, r, g, x, h);
      if (e) begin
        checks++;
        if (!h || (g !== x)) begin
          errors++;
          $display("FAIL %s_drain: got %h expected %h (have_exp=%0d)", tag, g, x, h);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain_timeout: %0d beats outstanding, expected 0", tag, sb.size());
    end
  endtask

  task automatic test_reset();
    logic e, v, r, h;
    logic [17:0] g, x;
    rst_n = 1'b0; in_valid = 1'b0; a = 16'h0; b = 16'h0; c0 = 1'b0; sub = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if ((out_valid !== 1'b0) || (sum !== 16'h0000) || (c4 !== 1'b0) || (ovf !== 1'b0)) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b sum=%h c4=%b ovf=%b expected 0/0000/0/0", out_valid, sum, c4, ovf);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    for (int i = 0; i < 6; i++)
      cyc(1'b1, 16'(i * 4097), 16'h1111, 1'b0, 1'b0, 1'b0, e, v, r, g, x, h);
    checks++;
    if (v !== 1'b1) begin
      errors++;
      $display("FAIL reset_fill: out_valid got %b expected 1", v);
    end
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ((out_valid !== 1'b0) || (sum !== 16'h0000) || (c4 !== 1'b0) || (ovf !== 1'b0)) begin
      errors++;
      $display("FAIL reset_midflight: got v=%b sum=%h c4=%b ovf=%b expected 0/0000/0/0", out_valid, sum, c4, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, e, v, r, g, x, h);
      checks++;
      if (v !== 1'b0) begin
        errors++;
        $display("FAIL reset_stale: cycle %0d out_valid got %b expected 0", i, v);
      end
    end
  endtask

  task automatic test_directed();
    logic e, v, r, h;
    logic [17:0] g, x;
    logic [15:0] ta [3];
    logic [15:0] tbv[3];
    logic        ts [3];
    logic [17:0] want[3];
    int          lat;
    ta[0] = 16'hFFFF; tbv[0] = 16'h0001; ts[0] = 1'b0; want[0] = {16'h0000, 1'b1, 1'b0};
    ta[1] = 16'h7FFF; tbv[1] = 16'h0001; ts[1] = 1'b0; want[1] = {16'h8000, 1'b0, 1'b1};
    ta[2] = 16'h0005; tbv[2] = 16'h0007; ts[2] = 1'b1; want[2] = {16'hFFFE, 1'b0, 1'b0};
    for (int t = 0; t < 3; t++) begin
      cyc(1'b1, ta[t], tbv[t], 1'b0, ts[t], 1'b1, e, v, r, g, x, h);
      lat = 0;
      e = 1'b0;
      while (!e && (lat < 20)) begin
        cyc(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, e, v, r, g, x, h);
        lat++;
      end
      checks++;
      if (lat != 4) begin
        errors++;
        $display("FAIL directed%0d_latency: got %0d cycles expected 4", t, lat);
      end
      checks++;
      if (g !== want[t]) begin
        errors++;
        $display("FAIL directed%0d_value: got {sum,c4,ovf}=%h expected %h", t, g, want[t]);
      end
      checks++;
      if (!h || (g !== x)) begin
        errors++;
        $display("FAIL directed%0d_model: got %h expected %h", t, g, x);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic e, v, r, h;
    logic [17:0] g, x;
    logic [15:0] ta, tbv;
    logic        exp_emit;
    for (int i = 0; i < 20; i++) begin
      ta  = 16'($urandom);
      tbv = 16'($urandom);
      cyc((i < 8) ? 1'b1 : 1'b0, ta, tbv, 1'($urandom), 1'($urandom), 1'b1, e, v, r, g, x, h);
      exp_emit = (i >= 4) && (i < 12);
      checks++;
      if (e !== exp_emit) begin
        errors++;
        $display("FAIL b2b_timing: cycle %0d emit got %b expected %b", i, e, exp_emit);
      end
      if (e) begin
        checks++;
        if (!h || (g !== x)) begin
          errors++;
          $display("FAIL b2b_value: cycle %0d got %h expected %h", i, g, x);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic e, v, r, h, tor, pv, por;
    logic [17:0] g, x, pg;
    pv = 1'b0; por = 1'b1; pg = 18'h0;
    for (int i = 0; i < 24; i++) begin
      tor = !((i >= 6) && (i < 12));
      cyc(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), tor, e, v, r, g, x, h);
      if (v && !tor) begin
        checks++;
        if (r !== 1'b0) begin
          errors++;
          $display("FAIL stall_in_ready: cycle %0d got %b expected 0", i, r);
        end
      end
      if (pv && !por) begin
        checks++;
        if ((v !== 1'b1) || (g !== pg)) begin
          errors++;
          $display("FAIL stall_hold: cycle %0d got v=%b %h expected v=1 %h", i, v, g, pg);
        end
      end
      if (e) begin
        checks++;
        if (!h || (g !== x)) begin
          errors++;
          $display("FAIL stall_value: cycle %0d got %h expected %h", i, g, x);
        end
      end
      pv = v; por = tor; pg = g;
    end
    test_drain("stall");
  endtask

  task automatic test_random();
    logic e, v, r, h, tor, tiv, pv, por;
    logic [17:0] g, x, pg;
    int accepted;
    int cycles;
    accepted = 0; cycles = 0;
    pv = 1'b0; por = 1'b1; pg = 18'h0;
    while ((accepted < 10000) && (cycles < 60000)) begin
      tiv = ($urandom_range(0, 3) != 0);
      tor = ($urandom_range(0, 3) != 0);
      cyc(tiv, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), tor, e, v, r, g, x, h);
      if (tiv && r) accepted++;
      cycles++;
      if (pv && !por) begin
        checks++;
        if ((v !== 1'b1) || (g !== pg)) begin
          errors++;
          $display("FAIL random_hold: cycle %0d got v=%b %h expected v=1 %h", cycles, v, g, pg);
        end
      end
      if (e) begin
        checks++;
        if (!h || (g !== x)) begin
          errors++;
          $display("FAIL random_value: cycle %0d got %h expected %h", cycles, g, x);
        end
      end
      pv = v; por = tor; pg = g;
    end
    checks++;
    if (accepted < 10000) begin
      errors++;
      $display("FAIL random_timeout: accepted %0d beats, expected 10000", accepted);
    end
    test_drain("random");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_drain("b2b");
    test_stall();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
